// File: rtl/dsm_spi_pkg.sv
// -----------------------------------------------------------------------------
// dsm_spi_pkg
//   Shared definitions for the SPI coefficient loader: header opcodes, header
//   field positions, the loader FSM state encoding and a helper for sizing
//   header fields.
// -----------------------------------------------------------------------------
package dsm_spi_pkg;

    // Header byte opcodes, found in header bits [7:6]
    localparam logic [1:0] OP_NOP    = 2'b00;
    localparam logic [1:0] OP_RSVD   = 2'b01;
    localparam logic [1:0] OP_WRITE  = 2'b10;
    localparam logic [1:0] OP_COMMIT = 2'b11;

    // Header field offsets. The bank field is left-aligned at bit 5, and the
    // start tap is right-aligned at bit 0.
    localparam int HDR_OP_HI   = 7;
    localparam int HDR_OP_LO   = 6;
    localparam int HDR_BANK_HI = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Width of a field that indexes n items. A single-item field still needs
    // one bit so that the part-selects stay legal.
    function automatic int field_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// -----------------------------------------------------------------------------
// spi_byte_shifter
//   SPI mode-0 receive shifter, MSB first. On every SCLK posedge with cs_n low,
//   it shifts in one MOSI bit. The byte is reported on the same edge that
//   samples its 8th bit. No extra register stage is used, so the caller can act
//   on that edge.
//
// Ports
//   SCLK             in   SPI clock
//   reset            in   synchronous, active-high
//   cs_n_i           in   chip select, active-low
//   mosi_i           in   serial data
//   byte_valid_o     out  high while the current edge completes a byte
//   byte_data_o      out  completed byte, {shift[6:0], mosi_i}
//   partial_abort_o  out  high while cs_n_i rises with a partial byte pending
// -----------------------------------------------------------------------------
module spi_byte_shifter (
    input  logic       SCLK,
    input  logic       reset,
    input  logic       cs_n_i,
    input  logic       mosi_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       partial_abort_o
);

    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (cs_n_i) begin
            bit_cnt_d = 3'd0;
        end else begin
            shift_d   = {shift_q[5:0], mosi_i};
            // The count wraps 7 -> 0 on its own when a byte completes.
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge SCLK) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign byte_valid_o    = !cs_n_i && (bit_cnt_q == 3'd7);
    assign byte_data_o     = {shift_q, mosi_i};
    assign partial_abort_o = cs_n_i && (bit_cnt_q != 3'd0);

endmodule

// File: rtl/spi_coef_loader.sv
// -----------------------------------------------------------------------------
// spi_coef_loader
//   SPI slave that loads FIR coefficient banks. The bank order is
//   0=cos_1, 1=sin_1, 2=cos_2, 3=sin_2.
//   WRITE frames fill shadow registers, and the tap pointer auto-increments.
//   A COMMIT frame copies every shadow bank into coef_o on one edge, so the
//   consumer never sees a half-written set.
//
// Ports
//   SCLK         in   SPI clock, the only clock of the block (not free-running)
//   reset        in   synchronous, active-high
//   cs_n         in   chip select, active-low
//   MOSI         in   serial data, sampled on posedge SCLK
//   coef_o       out  active coefficients; bank b, tap t at
//                     [(b*N_TAPS+t)*COEF_W +: COEF_W]
//   coef_update  out  one-cycle pulse after a commit
//   rx_err       out  one-cycle pulse on a protocol error
//   dbg_state_o  out  current FSM state (state_t encoding)
//
// Handshake: there is no valid/ready pair. A byte is consumed on the SCLK edge
// that samples its last bit, and the host can never be stalled.
// -----------------------------------------------------------------------------
module spi_coef_loader #(
    parameter int COEF_W  = 5,
    parameter int N_TAPS  = 8,
    parameter int N_BANKS = 4
) (
    input  logic                              SCLK,
    input  logic                              reset,
    input  logic                              cs_n,
    input  logic                              MOSI,
    output logic [N_BANKS*N_TAPS*COEF_W-1:0]  coef_o,
    output logic                              coef_update,
    output logic                              rx_err,
    output logic [1:0]                        dbg_state_o
);

    import dsm_spi_pkg::*;

    localparam int BW    = field_w(N_BANKS);
    localparam int TW    = field_w(N_TAPS);
    localparam int VEC_W = N_BANKS * N_TAPS * COEF_W;

    logic       byte_valid;
    logic [7:0] byte_data;
    logic       partial_abort;

    spi_byte_shifter u_shifter (
        .SCLK            (SCLK),
        .reset           (reset),
        .cs_n_i          (cs_n),
        .mosi_i          (MOSI),
        .byte_valid_o    (byte_valid),
        .byte_data_o     (byte_data),
        .partial_abort_o (partial_abort)
    );

    state_t             state_q, state_d;
    logic [BW-1:0]      bank_q, bank_d;
    logic [TW-1:0]      tap_q, tap_d;
    logic [VEC_W-1:0]   shadow_q, shadow_d;
    logic [VEC_W-1:0]   coef_q, coef_d;
    logic               upd_q, upd_d;
    logic               err_q, err_d;

    logic [1:0]         hdr_op;
    logic [BW-1:0]      hdr_bank;
    logic [TW-1:0]      hdr_tap;
    logic [BW+TW-1:0]   wr_idx;

    assign hdr_op   = byte_data[HDR_OP_HI:HDR_OP_LO];
    assign hdr_bank = byte_data[HDR_BANK_HI -: BW];
    assign hdr_tap  = byte_data[TW-1:0];
    // N_TAPS is a power of two, so {bank, tap} equals bank*N_TAPS + tap.
    assign wr_idx   = {bank_q, tap_q};

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        tap_d    = tap_q;
        shadow_d = shadow_q;
        coef_d   = coef_q;
        upd_d    = 1'b0;
        err_d    = 1'b0;

        if (cs_n) begin
            // The frame ends here. Any partial byte is dropped and flagged.
            state_d = ST_IDLE;
            err_d   = partial_abort;
        end else begin
            case (state_q)
                // The shifter has just taken header bit 7 on this edge.
                ST_IDLE: state_d = ST_HDR;

                ST_HDR: begin
                    if (byte_valid) begin
                        case (hdr_op)
                            OP_WRITE: begin
                                if (int'(hdr_bank) >= N_BANKS) begin
                                    err_d   = 1'b1;
                                    state_d = ST_DRAIN;
                                end else begin
                                    bank_d  = hdr_bank;
                                    tap_d   = hdr_tap;
                                    state_d = ST_DATA;
                                end
                            end
                            OP_COMMIT: begin
                                coef_d  = shadow_q;
                                upd_d   = 1'b1;
                                state_d = ST_DRAIN;
                            end
                            OP_RSVD: begin
                                err_d   = 1'b1;
                                state_d = ST_DRAIN;
                            end
                            OP_NOP:  state_d = ST_DRAIN;
                            default: state_d = ST_DRAIN;
                        endcase
                    end
                end

                ST_DATA: begin
                    if (byte_valid) begin
                        shadow_d[int'(wr_idx)*COEF_W +: COEF_W] = byte_data[COEF_W-1:0];
                        // The tap pointer wraps within the bank. The bank never advances.
                        tap_d = tap_q + 1'b1;
                    end
                end

                default: ;  // In ST_DRAIN, extra bytes are ignored silently.
            endcase
        end
    end

    always_ff @(posedge SCLK) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            bank_q   <= '0;
            tap_q    <= '0;
            shadow_q <= '0;
            coef_q   <= '0;
            upd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            tap_q    <= tap_d;
            shadow_q <= shadow_d;
            coef_q   <= coef_d;
            upd_q    <= upd_d;
            err_q    <= err_d;
        end
    end

    assign coef_o      = coef_q;
    assign coef_update = upd_q;
    assign rx_err      = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_coef_loader.sv
// -----------------------------------------------------------------------------
// tb_spi_coef_loader
//   Directed bench for spi_coef_loader with its default parameters.
//   A reference shadow model is updated as frames are driven. Each COMMIT
//   pushes the expected coef_o image into exp_q. A monitor pops that image on
//   every coef_update pulse, and otherwise requires coef_o to hold.
// -----------------------------------------------------------------------------
module tb_spi_coef_loader;
  import dsm_spi_pkg::*;

  localparam int COEF_W  = 5;
  localparam int N_TAPS  = 8;
  localparam int N_BANKS = 4;
  localparam int CW      = N_BANKS * N_TAPS * COEF_W;

  // ---------------- clock / reset ----------------
  logic          SCLK;
  logic          reset;
  logic          cs_n;
  logic          MOSI;
  logic [CW-1:0] coef_o;
  logic          coef_update;
  logic          rx_err;
  logic [1:0]    dbg_state_o;

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  spi_coef_loader #(
    .COEF_W  (COEF_W),
    .N_TAPS  (N_TAPS),
    .N_BANKS (N_BANKS)
  ) dut (
    .SCLK        (SCLK),
    .reset       (reset),
    .cs_n        (cs_n),
    .MOSI        (MOSI),
    .coef_o      (coef_o),
    .coef_update (coef_update),
    .rx_err      (rx_err),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  logic [CW-1:0] exp_q[$];
  logic [4:0]    m_sh[N_BANKS][N_TAPS];
  logic [CW-1:0] cur_active;
  logic [CW-1:0] exp_v;
  logic          mon_en;
  int            n_checks;
  int            n_errors;
  int            err_seen;
  int            upd_seen;
  int            exp_err;
  int            exp_upd;

  function automatic logic [CW-1:0] flatten();
    logic [CW-1:0] v;
    v = '0;
    for (int b = 0; b < N_BANKS; b++)
      for (int t = 0; t < N_TAPS; t++)
        v[(b*N_TAPS+t)*COEF_W +: COEF_W] = m_sh[b][t];
    return v;
  endfunction

  function automatic logic [4:0] tap_of(input logic [CW-1:0] v, input int b, input int t);
    return v[(b*N_TAPS+t)*COEF_W +: COEF_W];
  endfunction

  task automatic clear_model();
    for (int b = 0; b < N_BANKS; b++)
      for (int t = 0; t < N_TAPS; t++)
        m_sh[b][t] = 5'h00;
  endtask

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge SCLK) begin
    #1;
    if (!mon_en) begin
      cur_active = '0;
    end else begin
      if (rx_err === 1'b1) err_seen++;
      if (coef_update === 1'b1) begin
        upd_seen++;
        if (exp_q.size() == 0) begin
          check("coef_update_unexpected", {{(CW-1){1'b0}}, coef_update}, '0);
        end else begin
          exp_v = exp_q.pop_front();
          check("coef_commit", coef_o, exp_v);
          cur_active = exp_v;
        end
      end else begin
        check("coef_hold", coef_o, cur_active);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_bit(input logic cs, input logic bit_v);
    @(negedge SCLK);
    cs_n = cs;
    MOSI = bit_v;
    @(posedge SCLK);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) drive_bit(1'b0, b[i]);
  endtask

  task automatic end_frame();
    drive_bit(1'b1, 1'b0);
  endtask

  task automatic commit_frame(input string tag);
    exp_q.push_back(flatten());
    exp_upd++;
    send_byte(8'hC0);
    #2;
    check({tag, "_update_hi"}, {{(CW-1){1'b0}}, coef_update}, 1);
    check({tag, "_coef"}, coef_o, flatten());
    end_frame();
    #2;
    check({tag, "_update_lo"}, {{(CW-1){1'b0}}, coef_update}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    n_checks = 0; n_errors = 0; err_seen = 0; upd_seen = 0;
    exp_err = 0; exp_upd = 0; mon_en = 1'b0;
    clear_model();
    reset = 1'b1; cs_n = 1'b0; MOSI = 1'b0;

    // 1: reset with cs_n low and MOSI toggling
    for (int i = 0; i < 4; i++) begin
      @(negedge SCLK);
      MOSI = $urandom_range(0, 1);
      @(posedge SCLK);
    end
    #2;
    check("rst_coef", coef_o, '0);
    check("rst_update", {{(CW-1){1'b0}}, coef_update}, 0);
    check("rst_err", {{(CW-1){1'b0}}, rx_err}, 0);
    check("rst_state", {{(CW-2){1'b0}}, dbg_state_o}, {{(CW-2){1'b0}}, ST_IDLE});
    @(negedge SCLK);
    reset = 1'b0; cs_n = 1'b1; mon_en = 1'b1;

    // 2: WRITE bank0 tap2 with two bytes, then COMMIT
    send_byte(8'h8A);
    #2;
    check("t2_state_data", {{(CW-2){1'b0}}, dbg_state_o}, {{(CW-2){1'b0}}, ST_DATA});
    send_byte(8'h1F);
    send_byte(8'h03);
    end_frame();
    m_sh[0][2] = 5'h1F;
    m_sh[0][3] = 5'h03;
    #2;
    check("t2_precommit_coef", coef_o, '0);
    commit_frame("t2");
    check("t2_b0t2", {{(CW-5){1'b0}}, tap_of(coef_o, 0, 2)}, 5'h1F);
    check("t2_b0t3", {{(CW-5){1'b0}}, tap_of(coef_o, 0, 3)}, 5'h03);

    // 3: WRITE bank1 tap7 with wrap to tap0
    send_byte(8'h97);
    send_byte(8'h01);
    send_byte(8'h02);
    end_frame();
    m_sh[1][7] = 5'h01;
    m_sh[1][0] = 5'h02;
    commit_frame("t3");
    check("t3_b1t7", {{(CW-5){1'b0}}, tap_of(coef_o, 1, 7)}, 5'h01);
    check("t3_b1t0", {{(CW-5){1'b0}}, tap_of(coef_o, 1, 0)}, 5'h02);
    for (int t = 1; t < 7; t++)
      check("t3_b1_mid", {{(CW-5){1'b0}}, tap_of(coef_o, 1, t)}, 5'h00);

    // 4: reserved opcode; following bytes go to DRAIN. Then a NOP frame.
    send_byte(8'h40);
    exp_err++;
    #2;
    check("t4_rx_err", {{(CW-1){1'b0}}, rx_err}, 1);
    check("t4_state_drain", {{(CW-2){1'b0}}, dbg_state_o}, {{(CW-2){1'b0}}, ST_DRAIN});
    send_byte(8'h55);
    send_byte(8'h66);
    end_frame();
    send_byte(8'h00);
    send_byte(8'h12);
    end_frame();
    check("t4_err_count", err_seen, exp_err);
    commit_frame("t4");

    // 5: one full data byte, then a partial byte aborted by cs_n
    send_byte(8'hA1);
    send_byte(8'h0C);
    for (int i = 0; i < 5; i++) drive_bit(1'b0, 1'b1);
    end_frame();
    exp_err++;
    m_sh[2][1] = 5'h0C;
    #2;
    check("t5_rx_err", {{(CW-1){1'b0}}, rx_err}, 1);
    commit_frame("t5");
    check("t5_b2t1", {{(CW-5){1'b0}}, tap_of(coef_o, 2, 1)}, 5'h0C);
    check("t5_b2t2", {{(CW-5){1'b0}}, tap_of(coef_o, 2, 2)}, 5'h00);
    check("t5_err_count", err_seen, exp_err);

    // 6: reset in the middle of DATA, then commit, then upper bits ignored
    send_byte(8'h80);
    send_byte(8'h11);
    for (int i = 0; i < 3; i++) drive_bit(1'b0, 1'b1);
    @(negedge SCLK);
    mon_en = 1'b0; reset = 1'b1;
    @(posedge SCLK);
    @(negedge SCLK);
    @(posedge SCLK);
    #2;
    check("t6_rst_coef", coef_o, '0);
    check("t6_rst_state", {{(CW-2){1'b0}}, dbg_state_o}, {{(CW-2){1'b0}}, ST_IDLE});
    @(negedge SCLK);
    reset = 1'b0; cs_n = 1'b1; mon_en = 1'b1;
    clear_model();
    @(posedge SCLK);
    commit_frame("t6a");
    send_byte(8'hB5);
    send_byte(8'hE7);
    end_frame();
    m_sh[3][5] = 5'h07;
    commit_frame("t6b");
    check("t6_b3t5", {{(CW-5){1'b0}}, tap_of(coef_o, 3, 5)}, 5'h07);

    // final report
    repeat (2) @(posedge SCLK);
    #2;
    check("final_err_count", err_seen, exp_err);
    check("final_upd_count", upd_seen, exp_upd);
    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
